// File: rtl/bip2_control.sv
// BIP2 processor control unit: fetch/execute FSM, program counter, instruction
// register and Z/N status. Define BIP2_CTRL_INSTR_COUNT_EN to add instr_count_o.
module bip2_control #(
    parameter int MSB_DATA    = 16,
    parameter int MSB_OPERAND = 11,
    parameter int MSB_OPCODE  = 5
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    input  logic [MSB_DATA-1:0]    im_data_i,
    input  logic                   im_valid_i,
    input  logic                   flagZ_i,
    input  logic                   flagN_i,
    output logic [MSB_OPERAND-1:0] im_addr_o,
    output logic                   im_rd_o,
    output logic [1:0]             selA_o,
    output logic                   selB_o,
    output logic                   WRACC_o,
    output logic                   op_o,
    output logic                   WR_RAM_o,
    output logic [MSB_OPERAND-1:0] operand_o,
    output logic                   halt_o
`ifdef BIP2_CTRL_INSTR_COUNT_EN
    ,
    output logic [15:0]            instr_count_o
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [MSB_OPCODE-1:0] OP_HLT  = 'd0;
    localparam logic [MSB_OPCODE-1:0] OP_STO  = 'd1;
    localparam logic [MSB_OPCODE-1:0] OP_LD   = 'd2;
    localparam logic [MSB_OPCODE-1:0] OP_LDI  = 'd3;
    localparam logic [MSB_OPCODE-1:0] OP_ADD  = 'd4;
    localparam logic [MSB_OPCODE-1:0] OP_ADDI = 'd5;
    localparam logic [MSB_OPCODE-1:0] OP_SUB  = 'd6;
    localparam logic [MSB_OPCODE-1:0] OP_SUBI = 'd7;
    localparam logic [MSB_OPCODE-1:0] OP_BEQ  = 'd8;
    localparam logic [MSB_OPCODE-1:0] OP_BNE  = 'd9;
    localparam logic [MSB_OPCODE-1:0] OP_BGT  = 'd10;
    localparam logic [MSB_OPCODE-1:0] OP_BGE  = 'd11;
    localparam logic [MSB_OPCODE-1:0] OP_BLT  = 'd12;
    localparam logic [MSB_OPCODE-1:0] OP_BLE  = 'd13;
    localparam logic [MSB_OPCODE-1:0] OP_JMP  = 'd14;

    state_t                   state_q, state_d;
    logic [MSB_OPERAND-1:0]   pc_q, pc_d;
    logic [MSB_DATA-1:0]      ir_q, ir_d;
    logic                     z_q, z_d;
    logic                     n_q, n_d;
    logic [MSB_OPCODE-1:0]    opcode;
    logic [MSB_OPERAND-1:0]   operand;
    logic                     taken;
    logic                     is_alu;
`ifdef BIP2_CTRL_INSTR_COUNT_EN
    logic [15:0]              cnt_q, cnt_d;
`endif

    assign opcode  = ir_q[MSB_DATA-1 -: MSB_OPCODE];
    assign operand = ir_q[MSB_OPERAND-1:0];
    assign is_alu  = (opcode == OP_ADD) || (opcode == OP_ADDI) ||
                     (opcode == OP_SUB) || (opcode == OP_SUBI);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BEQ:  taken = z_q;
            OP_BNE:  taken = !z_q;
            OP_BGT:  taken = !z_q && !n_q;
            OP_BGE:  taken = !n_q;
            OP_BLT:  taken = n_q;
            OP_BLE:  taken = n_q || z_q;
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // State register and architectural registers
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
`ifdef BIP2_CTRL_INSTR_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            n_q     <= n_d;
`ifdef BIP2_CTRL_INSTR_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        z_d     = z_q;
        n_d     = n_q;
`ifdef BIP2_CTRL_INSTR_COUNT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE, HALTED: begin
                if (start_i) begin
                    state_d = FETCH;
                    pc_d    = '0;
                    z_d     = 1'b0;
                    n_d     = 1'b0;
`ifdef BIP2_CTRL_INSTR_COUNT_EN
                    cnt_d   = '0;
`endif
                end
            end
            FETCH: begin
                if (im_valid_i) begin
                    ir_d    = im_data_i;
                    state_d = EXEC;
                end
            end
            EXEC: begin
`ifdef BIP2_CTRL_INSTR_COUNT_EN
                cnt_d = cnt_q + 16'd1;
`endif
                if (opcode == OP_HLT) begin
                    state_d = HALTED;
                end else begin
                    state_d = FETCH;
                    pc_d    = taken ? operand : pc_q + 1'b1;
                    if (is_alu) begin
                        z_d = flagZ_i;
                        n_d = flagN_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls are combinational on state so reset drops them at once
    always_comb begin
        selA_o   = 2'b00;
        selB_o   = 1'b0;
        op_o     = 1'b0;
        WRACC_o  = 1'b0;
        WR_RAM_o = 1'b0;
        if (state_q == EXEC) begin
            case (opcode)
                OP_STO:  WR_RAM_o = 1'b1;
                OP_LD:   WRACC_o  = 1'b1;
                OP_LDI:  begin selA_o = 2'b01; WRACC_o = 1'b1; end
                OP_ADD:  begin selA_o = 2'b10; WRACC_o = 1'b1; end
                OP_ADDI: begin selA_o = 2'b10; selB_o = 1'b1; WRACC_o = 1'b1; end
                OP_SUB:  begin selA_o = 2'b10; op_o = 1'b1; WRACC_o = 1'b1; end
                OP_SUBI: begin selA_o = 2'b10; selB_o = 1'b1; op_o = 1'b1; WRACC_o = 1'b1; end
                default: ;
            endcase
        end
    end

    assign im_addr_o = pc_q;
    assign im_rd_o   = (state_q == FETCH);
    assign operand_o = operand;
    assign halt_o    = (state_q == HALTED);
`ifdef BIP2_CTRL_INSTR_COUNT_EN
    assign instr_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_bip2_control.sv
// Directed self-checking bench for bip2_control: program run, branches, fetch
// stalls, PC wrap and asynchronous reset during execute.
module tb_bip2_control;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] im_data;
    logic        im_valid;
    logic        flag_z;
    logic        flag_n;
    logic [10:0] im_addr;
    logic        im_rd;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        wracc;
    logic        op;
    logic        wr_ram;
    logic [10:0] operand;
    logic        halt;
`ifdef BIP2_CTRL_INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif
    logic [5:0]  ctrl;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // {selA, selB, op, WRACC, WR_RAM}
    assign ctrl = {sel_a, sel_b, op, wracc, wr_ram};

    bip2_control dut (
        .clock_i    (clk),
        .reset_n_i  (reset_n),
        .start_i    (start),
        .im_data_i  (im_data),
        .im_valid_i (im_valid),
        .flagZ_i    (flag_z),
        .flagN_i    (flag_n),
        .im_addr_o  (im_addr),
        .im_rd_o    (im_rd),
        .selA_o     (sel_a),
        .selB_o     (sel_b),
        .WRACC_o    (wracc),
        .op_o       (op),
        .WR_RAM_o   (wr_ram),
        .operand_o  (operand),
        .halt_o     (halt)
`ifdef BIP2_CTRL_INSTR_COUNT_EN
        ,
        .instr_count_o (instr_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for a single FETCH edge; leaves the DUT in EXEC.
    task automatic fetch(input logic [15:0] instr);
        im_data  = instr;
        im_valid = 1'b1;
        tick();
        im_valid = 1'b0;
        $display("instr %04h addr_after_fetch=%03h ctrl=%06b", instr, im_addr, ctrl);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; im_data = '0; im_valid = 1'b0;
        flag_z = 1'b0; flag_n = 1'b0;
        #3;
        checks++;
        if ({im_rd, halt, im_addr, operand, ctrl} !== 30'd0)
            $display("FAIL reset_outputs got rd=%b halt=%b addr=%h opnd=%h ctrl=%b want all 0",
                     im_rd, halt, im_addr, operand, ctrl);
        else passed++;
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (im_rd !== 1'b0 || halt !== 1'b0)
            $display("FAIL idle_hold got rd=%b halt=%b want 0 0", im_rd, halt);
        else passed++;
    endtask

    task automatic test_program();
        pulse_start();
        checks++;
        if (im_rd !== 1'b1 || im_addr !== 11'h000)
            $display("FAIL start_fetch got rd=%b addr=%h want 1 000", im_rd, im_addr);
        else passed++;
        fetch(16'h1805);            // LDI 5
        checks++;
        if (ctrl !== 6'b010010 || operand !== 11'd5)
            $display("FAIL ldi_exec got ctrl=%b opnd=%h want 010010 005", ctrl, operand);
        else passed++;
        tick();
        fetch(16'h2803);            // ADDI 3
        checks++;
        if (ctrl !== 6'b101010)
            $display("FAIL addi_exec got ctrl=%b want 101010", ctrl);
        else passed++;
        tick();
        checks++;
        if (im_addr !== 11'h002)
            $display("FAIL pc_inc got addr=%h want 002", im_addr);
        else passed++;
        fetch(16'h0807);            // STO 7
        checks++;
        if (ctrl !== 6'b000001 || operand !== 11'd7)
            $display("FAIL sto_exec got ctrl=%b opnd=%h want 000001 007", ctrl, operand);
        else passed++;
        tick();
        fetch(16'h0000);            // HLT
        checks++;
        if (ctrl !== 6'b000000 || halt !== 1'b0)
            $display("FAIL hlt_exec got ctrl=%b halt=%b want 000000 0", ctrl, halt);
        else passed++;
        tick();
        checks++;
        if (halt !== 1'b1 || im_rd !== 1'b0 || im_addr !== 11'h003)
            $display("FAIL halted got halt=%b rd=%b addr=%h want 1 0 003", halt, im_rd, im_addr);
        else passed++;
`ifdef BIP2_CTRL_INSTR_COUNT_EN
        checks++;
        if (instr_count !== 16'd4)
            $display("FAIL instr_count got %0d want 4", instr_count);
        else passed++;
`endif
        tick();
        checks++;
        if (halt !== 1'b1)
            $display("FAIL halt_hold got halt=%b want 1", halt);
        else passed++;
    endtask

    task automatic test_branch();
        pulse_start();
        checks++;
        if (im_addr !== 11'h000 || im_rd !== 1'b1)
            $display("FAIL restart got addr=%h rd=%b want 000 1", im_addr, im_rd);
        else passed++;
        fetch(16'h3805);            // SUBI 5, result zero
        flag_z = 1'b1; flag_n = 1'b0;
        checks++;
        if (ctrl !== 6'b101110)
            $display("FAIL subi_exec got ctrl=%b want 101110", ctrl);
        else passed++;
        tick();
        flag_z = 1'b0;
        fetch(16'h4020);            // BEQ 0x020
        checks++;
        if (ctrl !== 6'b000000)
            $display("FAIL beq_ctrl got ctrl=%b want 000000", ctrl);
        else passed++;
        tick();
        checks++;
        if (im_addr !== 11'h020)
            $display("FAIL beq_taken got addr=%h want 020", im_addr);
        else passed++;
        fetch(16'h3805);            // SUBI 5, result nonzero
        flag_z = 1'b0;
        tick();
        flag_z = 1'b1;              // ignored: not an ALU instruction
        fetch(16'h4020);            // BEQ 0x020
        tick();
        flag_z = 1'b0;
        checks++;
        if (im_addr !== 11'h022)
            $display("FAIL beq_not_taken got addr=%h want 022", im_addr);
        else passed++;
    endtask

    task automatic test_stall();
        start    = 1'b1;            // must be ignored in FETCH
        im_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (im_rd !== 1'b1 || im_addr !== 11'h022 || ctrl !== 6'b000000)
                $display("FAIL stall_%0d got rd=%b addr=%h ctrl=%b want 1 022 000000",
                         i, im_rd, im_addr, ctrl);
            else passed++;
        end
        start = 1'b0;
        fetch(16'h1004);            // LD 4
        checks++;
        if (ctrl !== 6'b000010 || operand !== 11'd4)
            $display("FAIL ld_exec got ctrl=%b opnd=%h want 000010 004", ctrl, operand);
        else passed++;
        tick();
        checks++;
        if (im_addr !== 11'h023)
            $display("FAIL ld_pc got addr=%h want 023", im_addr);
        else passed++;
    endtask

    task automatic test_wrap();
        fetch(16'h77FF);            // JMP 0x7FF
        tick();
        checks++;
        if (im_addr !== 11'h7FF)
            $display("FAIL jmp_7ff got addr=%h want 7ff", im_addr);
        else passed++;
        fetch(16'h1801);            // LDI 1 at 0x7FF
        tick();
        checks++;
        if (im_addr !== 11'h000)
            $display("FAIL pc_wrap got addr=%h want 000", im_addr);
        else passed++;
        fetch(16'hF800);            // undefined opcode -> NOP
        checks++;
        if (ctrl !== 6'b000000)
            $display("FAIL nop_ctrl got ctrl=%b want 000000", ctrl);
        else passed++;
        tick();
        checks++;
        if (im_addr !== 11'h001)
            $display("FAIL nop_pc got addr=%h want 001", im_addr);
        else passed++;
    endtask

    task automatic test_reset_exec();
        fetch(16'h0809);            // STO 9
        checks++;
        if (wr_ram !== 1'b1)
            $display("FAIL sto9_exec got wr_ram=%b want 1", wr_ram);
        else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (wr_ram !== 1'b0 || im_rd !== 1'b0 || halt !== 1'b0 || im_addr !== 11'h000 ||
            operand !== 11'h000)
            $display("FAIL async_reset got wr_ram=%b rd=%b halt=%b addr=%h opnd=%h want 0 0 0 000 000",
                     wr_ram, im_rd, halt, im_addr, operand);
        else passed++;
`ifdef BIP2_CTRL_INSTR_COUNT_EN
        checks++;
        if (instr_count !== 16'd0)
            $display("FAIL count_reset got %0d want 0", instr_count);
        else passed++;
`endif
        tick();
        reset_n = 1'b1;
        tick(); tick();
        checks++;
        if (im_rd !== 1'b0 || ctrl !== 6'b000000)
            $display("FAIL post_reset_idle got rd=%b ctrl=%b want 0 000000", im_rd, ctrl);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_program();
        test_branch();
        test_stall();
        test_wrap();
        test_reset_exec();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
